// File: rtl/gather_pkg.sv
// gather_pkg: shared state encoding and default widths for the gather output packer
package gather_pkg;
  localparam int DEF_OUT_WIDTH  = 32;
  localparam int DEF_LEN_WIDTH  = 16;
  localparam int DEF_FIFO_DEPTH = 16;
  typedef enum logic [1:0] {IDLE, PACK, DRAIN} pack_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: ring-buffer FIFO whose head word is always presented from storage flops
module sync_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;
  logic          do_push, do_pop;
  assign do_pop  = i_pop & ~o_empty;
  // a full FIFO still takes a word when the head leaves in the same cycle
  assign do_push = i_push & (~o_full | do_pop);
  assign o_empty = cnt == '0;
  assign o_full  = cnt == (AW+1)'(DEPTH);
  assign o_data  = mem[rptr];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= i_data;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/gather_out_packer.sv
// gather_out_packer: packs gathered bytes MSB-first into words, frames them and streams them out
module gather_out_packer import gather_pkg::*; #(
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
  parameter int IN_WIDTH   = OUT_WIDTH / 4,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [LEN_WIDTH-1:0] i_frame_len,
  input  logic                 i_gather_valid,
  input  logic [IN_WIDTH-1:0]  i_gather_data,
  output logic [OUT_WIDTH-1:0] o_m_tdata,
  output logic                 o_m_tvalid,
  input  logic                 i_m_tready,
  output logic                 o_m_tlast,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overflow
);
  localparam int LANES = OUT_WIDTH / IN_WIDTH;
  localparam int LW    = $clog2(LANES);
  pack_state_t                 state;
  logic [LW-1:0]               lane;
  logic [OUT_WIDTH-IN_WIDTH-1:0] acc;
  logic [LEN_WIDTH-1:0]        len_q, word_cnt;
  logic                        pend_v, pend_last;
  logic [OUT_WIDTH-1:0]        pend_data;
  logic                        fifo_full, fifo_empty, pop, push_ok;
  assign o_m_tvalid = ~fifo_empty;
  assign pop        = o_m_tvalid & i_m_tready;
  assign push_ok    = ~fifo_full | pop;
  sync_fifo #(.W(OUT_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (pend_v),
    .i_data  ({pend_last, pend_data}),
    .i_pop   (pop),
    .o_data  ({o_m_tlast, o_m_tdata}),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state      <= IDLE;
      lane       <= '0;
      acc        <= '0;
      len_q      <= '0;
      word_cnt   <= '0;
      pend_v     <= 1'b0;
      pend_last  <= 1'b0;
      pend_data  <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_done <= 1'b0;
      pend_v <= 1'b0;
      // a refused word is lost and does not advance the frame position
      if (pend_v && push_ok) begin
        word_cnt <= pend_last ? '0 : word_cnt + 1'b1;
        if (pend_last) state <= DRAIN;
      end
      if (pend_v && !push_ok) o_overflow <= 1'b1;
      case (state)
        IDLE: if (i_start) begin
          o_overflow <= 1'b0;
          if (i_frame_len == '0) o_done <= 1'b1;
          else begin
            state    <= PACK;
            len_q    <= i_frame_len;
            lane     <= '0;
            word_cnt <= '0;
            o_busy   <= 1'b1;
          end
        end
        PACK: if (i_gather_valid) begin
          lane <= lane + 1'b1;
          if (lane == LW'(LANES - 1)) begin
            pend_v    <= 1'b1;
            pend_data <= {acc, i_gather_data};
            pend_last <= word_cnt == len_q - 1'b1;
          end else acc[(LANES - 2 - int'(lane)) * IN_WIDTH +: IN_WIDTH] <= i_gather_data;
        end
        DRAIN: if (pop && o_m_tlast) begin
          state  <= IDLE;
          o_done <= 1'b1;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_gather_out_packer.sv
// tb_gather_out_packer: table vectors, directed corner sequences and random frames vs a byte-list model
module tb_gather_out_packer;
  logic        clk = 0, rst_n = 0, start = 0, valid = 0, tready = 0;
  logic [15:0] flen = '0;
  logic [7:0]  gdata = '0;
  logic [31:0] tdata;
  logic        tvalid, tlast, busy, done, ovf;
  int          n_cmp = 0, n_fail = 0, cyc = 0, done_cnt = 0, first_tv = -1;
  int          rx_base = 0, done_base = 0, b4_cyc = 0;
  logic [32:0] rxq[$];
  logic [7:0]  bq[$];

  typedef struct {
    logic [15:0] len;
    logic [7:0]  base;
    logic [31:0] first_w;
    logic [31:0] last_w;
  } vec_t;
  vec_t vt[4];

  gather_out_packer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_frame_len(flen),
    .i_gather_valid(valid), .i_gather_data(gdata),
    .o_m_tdata(tdata), .o_m_tvalid(tvalid), .i_m_tready(tready), .o_m_tlast(tlast),
    .o_busy(busy), .o_done(done), .o_overflow(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (rst_n) begin
      if (done) done_cnt++;
      if (tvalid && first_tv < 0) first_tv = cyc;
      if (tvalid && tready) rxq.push_back({tlast, tdata});
    end else begin
      rxq.delete();
      done_cnt = 0;
      first_tv = -1;
    end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 0; start = 0; valid = 0; tready = 0;
    step; step;
    rst_n = 1;
    step;
  endtask

  task automatic begin_frame(input logic [15:0] len);
    bq.delete();
    rx_base = rxq.size();
    done_base = done_cnt;
    start = 1; flen = len;
    step;
    start = 0;
  endtask

  task automatic send(input logic [7:0] b);
    valid = 1; gdata = b;
    bq.push_back(b);
    if (bq.size() == 4) b4_cyc = cyc;
    step;
    valid = 0;
  endtask

  task automatic wait_done(input string nm, input int budget, input bit rnd);
    int k;
    k = 0;
    while (done_cnt == done_base && k < budget) begin
      if (rnd) tready = 1'($urandom);
      step;
      k++;
    end
    chk({nm, " done"}, 64'(done_cnt - done_base), 64'd1);
  endtask

  // word k of a frame is bytes 4k..4k+3 in arrival order, first byte in the top lane
  task automatic check_frame(input string nm, input int n, input int len);
    logic [32:0] exp, got;
    chk({nm, " nwords"}, 64'(rxq.size() - rx_base), 64'(n));
    for (int k = 0; k < n; k++) begin
      exp = {k == len - 1, bq[4*k], bq[4*k+1], bq[4*k+2], bq[4*k+3]};
      got = (rx_base + k < rxq.size()) ? rxq[rx_base + k] : '1;
      chk($sformatf("%s w%0d", nm, k), 64'(got), 64'(exp));
    end
  endtask

  initial begin
    vt[0] = '{16'd2, 8'h11, 32'h11121314, 32'h15161718};
    vt[1] = '{16'd1, 8'hA0, 32'hA0A1A2A3, 32'hA0A1A2A3};
    vt[2] = '{16'd3, 8'hFD, 32'hFDFEFF00, 32'h05060708};
    vt[3] = '{16'd4, 8'h7E, 32'h7E7F8081, 32'h8A8B8C8D};

    do_reset;
    chk("reset outs", 64'({tdata, tvalid, tlast, busy, done, ovf}), 64'd0);

    foreach (vt[v]) begin
      do_reset;
      tready = 1;
      begin_frame(vt[v].len);
      chk($sformatf("v%0d busy", v), 64'(busy), 64'd1);
      for (int i = 0; i < 4 * int'(vt[v].len); i++) send(vt[v].base + 8'(i));
      wait_done($sformatf("v%0d", v), 50, 0);
      chk($sformatf("v%0d nwords", v), 64'(rxq.size()), 64'(vt[v].len));
      chk($sformatf("v%0d first", v), 64'(rxq.size() > 0 ? rxq[0] : '1), 64'({vt[v].len == 1, vt[v].first_w}));
      chk($sformatf("v%0d last", v), 64'(rxq.size() > 0 ? rxq[rxq.size()-1] : '1), 64'({1'b1, vt[v].last_w}));
      chk($sformatf("v%0d latency", v), 64'(first_tv - b4_cyc), 64'd2);
      step; step;
      chk($sformatf("v%0d done once", v), 64'(done_cnt), 64'd1);
      chk($sformatf("v%0d busy end", v), 64'(busy), 64'd0);
    end

    do_reset;
    begin_frame(16'd0);
    chk("len0 done", 64'(done), 64'd1);
    chk("len0 busy", 64'(busy), 64'd0);
    step;
    chk("len0 done off", 64'(done), 64'd0);
    repeat (3) step;
    chk("len0 busy2", 64'(busy), 64'd0);
    chk("len0 no word", 64'(first_tv), -64'sd1);

    do_reset;
    tready = 0;
    begin_frame(16'd20);
    for (int i = 0; i < 80; i++) send(8'(i + 1));
    step; step;
    chk("stall ovf", 64'(ovf), 64'd1);
    for (int j = 0; j < 3; j++) begin
      chk("stall hold", 64'({tvalid, tlast, tdata}), 64'({1'b1, 1'b0, bq[0], bq[1], bq[2], bq[3]}));
      step;
    end
    tready = 1;
    repeat (24) step;
    check_frame("stall", 16, 20);
    chk("stall busy", 64'(busy), 64'd1);
    chk("stall no done", 64'(done_cnt - done_base), 64'd0);
    chk("stall empty", 64'(tvalid), 64'd0);

    do_reset;
    tready = 0;
    begin_frame(16'd20);
    for (int i = 0; i < 64; i++) send(8'(i + 1));
    step; step;
    chk("full no ovf", 64'(ovf), 64'd0);
    for (int i = 64; i < 68; i++) send(8'(i + 1));
    tready = 1;
    step;
    tready = 0;
    step;
    chk("full+pop ovf", 64'(ovf), 64'd0);
    tready = 1;
    for (int i = 68; i < 80; i++) send(8'(i + 1));
    wait_done("full+pop", 100, 0);
    check_frame("full+pop", 20, 20);
    chk("full+pop ovf end", 64'(ovf), 64'd0);

    do_reset;
    tready = 0;
    begin_frame(16'd4);
    for (int i = 0; i < 6; i++) send(8'h51 + 8'(i));
    step;
    chk("pre-rst tvalid", 64'(tvalid), 64'd1);
    #2 rst_n = 0;
    #1 chk("async rst outs", 64'({tdata, tvalid, tlast, busy, done, ovf}), 64'd0);
    step;
    rst_n = 1;
    step;
    tready = 1;
    begin_frame(16'd1);
    for (int i = 0; i < 4; i++) send(8'hC1 + 8'(i));
    wait_done("post-rst", 50, 0);
    check_frame("post-rst", 1, 1);

    do_reset;
    tready = 1;
    for (int i = 0; i < 4; i++) begin
      valid = 1; gdata = 8'hEE;
      step;
    end
    valid = 0;
    begin_frame(16'd1);
    start = 1; flen = 16'd3;
    step;
    start = 0;
    for (int i = 0; i < 4; i++) send(8'h31 + 8'(i));
    wait_done("ignore", 50, 0);
    check_frame("ignore", 1, 1);
    step; step;
    chk("ignore done once", 64'(done_cnt - done_base), 64'd1);

    do_reset;
    for (int f = 0; f < 8; f++) begin
      int len;
      len = int'($urandom_range(1, 6));
      begin_frame(16'(len));
      for (int i = 0; i < 4 * len; i++) begin
        while ($urandom_range(0, 2) == 0) begin
          tready = 1'($urandom);
          step;
        end
        tready = 1'($urandom);
        send(8'($urandom));
      end
      wait_done($sformatf("rnd%0d", f), 400, 1);
      tready = 1;
      check_frame($sformatf("rnd%0d", f), len, len);
      chk($sformatf("rnd%0d ovf", f), 64'(ovf), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
